seven_segment_reader: RTL and testbench
=======================================

Name: seven_segment_reader

Overview:
- Receiver end of our multiplexed seven-segment display interface: snoops the segment lines plus the one-hot digit strobes driven by a scanned display.
- Filters glitches by requiring each pattern to be stable, decodes it back to a BCD digit value and holds one value per digit position.
- Used for self-checking display paths and for reading back panels driven by the segment decoders.

Parameters:
NUM_DIGITS, 4, number of scanned digit positions (1..8)
STABLE_CYCLES, 3, consecutive identical samples required before capture (2..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
seg  input  7  segment lines, active-high, {a,b,c,d,e,f,g} = seg[6:0]
digit_en  input  NUM_DIGITS  digit strobe, active-high, one-hot when valid
digits  output  4*NUM_DIGITS  decoded value per position; position i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  bit i set once position i has been captured
update_pulse  output  1  one-cycle pulse when any position is captured
pattern_error  output  1  one-cycle pulse when a captured pattern is unrecognised

Behaviour:
- Reset (asynchronous, any time including mid-capture): digits=0, digit_valid=0, update_pulse=0, pattern_error=0, sample registers=0, stability counter=0, armed flag=1. Reset aborts any capture in progress.
- Input stage: seg and digit_en are registered on every rising edge into sample registers. These are the only paths from the asynchronous panel lines.
- Stability counter increments (saturating at STABLE_CYCLES) when both conditions hold:
  - the new sample equals the previous sample in both seg and digit_en;
  - digit_en is exactly one-hot.
- Otherwise the counter loads 1 if digit_en is one-hot, else 0, and the armed flag is set to 1.
- Capture rule: when the counter reaches STABLE_CYCLES and armed=1:
  - decode the sample and write it into position i, where i is the index of the set digit_en bit;
  - set digit_valid[i];
  - pulse update_pulse;
  - clear armed.
- A held pair is captured exactly once; re-capture only after seg or digit_en changes.
- Latency: a pair first present at the inputs before edge k is captured, and outputs change, on edge k+STABLE_CYCLES.
  - Example, STABLE_CYCLES=3: sampled on edges k, k+1, k+2; outputs change on edge k+3.
- Decode table (seg hex -> value):
  - 0x7E->0, 0x30->1, 0x6D->2, 0x79->3, 0x33->4, 0x5B->5, 0x5F->6, 0x70->7, 0x7F->8, 0x7B->9.
  - 0x00 (blank) -> 0xE; no error.
  - Any other pattern -> 0xF, and pattern_error pulses in the same cycle as update_pulse.
- Invalid strobe (digit_en zero or multi-hot): never captures and resets the counter. Existing digits and digit_valid are unchanged.
- Strobe moves to a new position while seg is unchanged: treated as a change; the counter restarts at 1.
- Positions not strobed keep their last value indefinitely; there is no timeout.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then seg=0x6D, digit_en=0001 held 5 cycles -> digits[3:0]=2, digit_valid=0001, update_pulse high exactly 1 cycle, 3 edges after the first sample.
2. Scan positions 0..3 with 0x30, 0x79, 0x33, 0x7B, 4 cycles each -> digits=0x9431, digit_valid=1111, 4 update_pulses, no pattern_error.
3. Glitch: seg=0x7F for 2 cycles, then 0x70 held 4 cycles on position 1 -> position 1 = 7 only; one update_pulse; 8 never captured.
4. seg=0x01 held 3+ cycles on position 2 -> position 2 = 0xF, pattern_error and update_pulse each pulse once. Then seg=0x00 -> position 2 = 0xE, no error.
5. digit_en=0011 or 0000 with seg=0x7E for 10 cycles -> no update_pulse; digits and digit_valid unchanged.
6. Reset asserted 1 cycle after a capture (and separately mid-count) -> all outputs 0 immediately, no pulse afterward. Fresh pattern after reset is captured at the full STABLE_CYCLES latency.

Source files
------------

// File: rtl/seven_segment_reader.sv
// Receiver for a scanned seven-segment display: debounces each segment/strobe pair,
// decodes the segment pattern back to a digit value and holds one value per position.
module seven_segment_reader #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic                    update_pulse_o,
    output logic                    pattern_error_o
);

    localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

    logic [6:0]              seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   en_q, en_prev_q;
    logic [3:0]              cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    update_q, update_d;
    logic                    error_q, error_d;

    logic       onehot;
    logic       same;
    logic       capture;
    logic [3:0] value;
    logic       unknown;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            seg_q      <= '0;
            seg_prev_q <= '0;
            en_q       <= '0;
            en_prev_q  <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            digits_q   <= '0;
            valid_q    <= '0;
            update_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            seg_q      <= seg_i;
            seg_prev_q <= seg_q;
            en_q       <= digit_en_i;
            en_prev_q  <= en_q;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        value   = 4'hF;
        unknown = 1'b0;
        case (seg_q)
            7'h7E:   value = 4'd0;
            7'h30:   value = 4'd1;
            7'h6D:   value = 4'd2;
            7'h79:   value = 4'd3;
            7'h33:   value = 4'd4;
            7'h5B:   value = 4'd5;
            7'h5F:   value = 4'd6;
            7'h70:   value = 4'd7;
            7'h7F:   value = 4'd8;
            7'h7B:   value = 4'd9;
            7'h00:   value = 4'hE;
            default: unknown = 1'b1;
        endcase
    end

    always_comb begin
        onehot   = (en_q != '0) && ((en_q & (en_q - NUM_DIGITS'(1))) == '0);
        same     = (seg_q == seg_prev_q) && (en_q == en_prev_q);
        cnt_d    = onehot ? 4'd1 : 4'd0;
        armed_d  = 1'b1;
        capture  = 1'b0;
        digits_d = digits_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        error_d  = 1'b0;

        if (same && onehot) begin
            cnt_d   = (cnt_q >= StableMax) ? StableMax : cnt_q + 4'd1;
            armed_d = armed_q;
            // Capture on the edge the count reaches its target, so latency is exactly
            // STABLE_CYCLES edges from the first sampling edge.
            capture = armed_q && (cnt_d == StableMax);
        end

        if (capture) begin
            armed_d  = 1'b0;
            update_d = 1'b1;
            error_d  = unknown;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (en_q[i]) begin
                    digits_d[4*i +: 4] = value;
                    valid_d[i]         = 1'b1;
                end
            end
        end
    end

    assign digits_o        = digits_q;
    assign digit_valid_o   = valid_q;
    assign update_pulse_o  = update_q;
    assign pattern_error_o = error_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with NUM_DIGITS=4, STABLE_CYCLES=3.
module tb_seven_segment_reader;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        update_pulse;
    logic        pattern_error;

    int checks = 0;
    int errors = 0;
    int upd_total = 0;
    int err_total = 0;
    int both_total = 0;
    int upd_base, err_base, both_base;

    seven_segment_reader #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(3)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .seg_i          (seg),
        .digit_en_i     (digit_en),
        .digits_o       (digits),
        .digit_valid_o  (digit_valid),
        .update_pulse_o (update_pulse),
        .pattern_error_o(pattern_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update_pulse === 1'b1) upd_total++;
        if (pattern_error === 1'b1) err_total++;
        if (update_pulse === 1'b1 && pattern_error === 1'b1) both_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        @(negedge clk);
        upd_base  = upd_total;
        err_base  = err_total;
        both_base = both_total;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_digits"}, 32'(digits), 32'h0);
        chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
        chk({tag, "_upd"}, 32'(update_pulse), 32'h0);
        chk({tag, "_err"}, 32'(pattern_error), 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        seg      = 7'h00;
        digit_en = 4'b0000;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Test 1: exact capture latency and single-cycle pulse
        seg      = 7'h6D;
        digit_en = 4'b0001;
        tick(1); chk("t1_k0_upd", 32'(update_pulse), 32'h0);
        tick(1); chk("t1_k1_upd", 32'(update_pulse), 32'h0);
        tick(1); chk("t1_k2_upd", 32'(update_pulse), 32'h0);
        tick(1);
        chk("t1_k3_upd", 32'(update_pulse), 32'h1);
        chk("t1_digits", 32'(digits), 32'h0002);
        chk("t1_valid", 32'(digit_valid), 32'h1);
        chk("t1_err", 32'(pattern_error), 32'h0);
        tick(1); chk("t1_k4_upd", 32'(update_pulse), 32'h0);

        // Test 2: scan all positions
        snap();
        seg = 7'h30; digit_en = 4'b0001; tick(4);
        seg = 7'h79; digit_en = 4'b0010; tick(4);
        seg = 7'h33; digit_en = 4'b0100; tick(4);
        seg = 7'h7B; digit_en = 4'b1000; tick(4);
        tick(1);
        chk("t2_digits", 32'(digits), 32'h9431);
        chk("t2_valid", 32'(digit_valid), 32'hF);
        chk("t2_pulses", 32'(upd_total - upd_base), 32'd4);
        chk("t2_errs", 32'(err_total - err_base), 32'd0);

        // Test 3: short-lived 8 must be ignored
        snap();
        digit_en = 4'b0010;
        seg = 7'h7F; tick(2);
        seg = 7'h70; tick(4);
        tick(1);
        chk("t3_digits", 32'(digits), 32'h9471);
        chk("t3_pulses", 32'(upd_total - upd_base), 32'd1);

        // Test 4: unknown pattern then blank
        snap();
        digit_en = 4'b0100;
        seg = 7'h01; tick(4);
        tick(1);
        chk("t4_digits_bad", 32'(digits), 32'h9F71);
        chk("t4_pulses_bad", 32'(upd_total - upd_base), 32'd1);
        chk("t4_errs_bad", 32'(err_total - err_base), 32'd1);
        chk("t4_coincident", 32'(both_total - both_base), 32'd1);
        snap();
        seg = 7'h00; tick(4);
        tick(1);
        chk("t4_digits_blank", 32'(digits), 32'h9E71);
        chk("t4_pulses_blank", 32'(upd_total - upd_base), 32'd1);
        chk("t4_errs_blank", 32'(err_total - err_base), 32'd0);

        // Test 5: invalid strobes never capture
        snap();
        seg = 7'h7E;
        digit_en = 4'b0011; tick(10);
        digit_en = 4'b0000; tick(10);
        chk("t5_pulses", 32'(upd_total - upd_base), 32'd0);
        chk("t5_digits", 32'(digits), 32'h9E71);
        chk("t5_valid", 32'(digit_valid), 32'hF);

        // Test 6a: reset one cycle after a capture
        seg = 7'h5B; digit_en = 4'b0001;
        tick(4);
        chk("t6a_upd", 32'(update_pulse), 32'h1);
        chk("t6a_digits", 32'(digits), 32'h9E75);
        tick(1);
        #2 reset = 1'b1;
        #1 chk_all_zero("t6a_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        tick(1); chk("t6a_k0_upd", 32'(update_pulse), 32'h0);
        tick(1); chk("t6a_k1_upd", 32'(update_pulse), 32'h0);
        tick(1); chk("t6a_k2_upd", 32'(update_pulse), 32'h0);
        tick(1);
        chk("t6a_k3_upd", 32'(update_pulse), 32'h1);
        chk("t6a_k3_digits", 32'(digits), 32'h0005);
        chk("t6a_k3_valid", 32'(digit_valid), 32'h1);

        // Test 6b: reset in the middle of a count
        seg = 7'h5F; digit_en = 4'b0010;
        tick(2);
        #2 reset = 1'b1;
        #1 chk_all_zero("t6b_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        seg = 7'h7E; digit_en = 4'b1000;
        tick(1); chk("t6b_k0_upd", 32'(update_pulse), 32'h0);
        tick(1); chk("t6b_k1_upd", 32'(update_pulse), 32'h0);
        tick(1); chk("t6b_k2_upd", 32'(update_pulse), 32'h0);
        tick(1);
        chk("t6b_k3_upd", 32'(update_pulse), 32'h1);
        chk("t6b_k3_digits", 32'(digits), 32'h0000);
        chk("t6b_k3_valid", 32'(digit_valid), 32'h8);
        tick(3);
        chk("t6b_hold_upd", 32'(update_pulse), 32'h0);
        chk("t6b_hold_valid", 32'(digit_valid), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
